// File: rtl/cpu_jtag_ocimem.sv
// Debug RAM and monitor registers for the JTAG debug path; JTAG commands
// share a single-port byte-enabled RAM with a CPU Avalon-MM slave, JTAG first.
module cpu_jtag_ocimem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, J_CAP, CPU_RD} state_t;
  typedef enum logic [1:0] {P_RD, P_RDINC, P_WR} pend_t;

  state_t r_state, w_state_nxt;
  pend_t  r_pend_type;
  logic   r_pend_v;
  logic   r_ready, r_error;
  logic [31:0]       r_mon_d;
  logic [ADDR_W-1:0] r_mon_a;
  logic [31:0]       r_mem [0:(1<<ADDR_W)-1];
  logic [31:0]       r_q;

  logic w_win_a, w_win_b, w_win_n, w_any, w_busy, w_accept, w_drop, w_queue;
  logic w_ram_we, w_ram_re, w_jwr_done, w_jcap;
  logic [3:0]        w_ram_be;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [31:0]       w_ram_wdata;
  logic              w_unused;

  assign w_unused = ^{jdo[37:36], jdo[2:0]};

  // Strobe arbitration: b > a > no_action; J_CAP is busy so that its
  // MonDReg/MonAReg updates never collide with a command load.
  assign w_win_b  = take_action_ocimem_b;
  assign w_win_a  = take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_win_n  = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_any    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_busy   = r_pend_v | (r_state == J_CAP);
  assign w_accept = w_any & ~w_busy;
  assign w_drop   = (w_any & w_busy)
                  | (take_action_ocimem_b & (take_action_ocimem_a | take_no_action_ocimem_a))
                  | (take_action_ocimem_a & take_no_action_ocimem_a);
  assign w_queue  = w_accept & (w_win_b | w_win_n | (w_win_a & jdo[35]));

  always_comb begin
    w_state_nxt = r_state;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_be    = '0;
    w_ram_addr  = r_mon_a;
    w_ram_wdata = r_mon_d;
    w_jwr_done  = 1'b0;
    w_jcap      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pend_v) begin
          if (r_pend_type == P_WR) begin
            w_ram_we   = 1'b1;
            w_ram_be   = '1;
            w_jwr_done = 1'b1;
          end else begin
            w_ram_re    = 1'b1;
            w_state_nxt = J_CAP;
          end
        end else if (!w_queue) begin
          // A JTAG command being latched this cycle defers the CPU request.
          if (read) begin
            w_ram_re    = 1'b1;
            w_ram_addr  = address;
            w_state_nxt = CPU_RD;
          end else if (write) begin
            w_ram_we    = 1'b1;
            w_ram_be    = byteenable;
            w_ram_addr  = address;
            w_ram_wdata = writedata;
          end
        end
      end
      J_CAP: begin
        w_jcap      = 1'b1;
        w_state_nxt = IDLE;
      end
      CPU_RD:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_ram_be[i]) r_mem[w_ram_addr][8*i +: 8] <= w_ram_wdata[8*i +: 8];
      end
    end
    if (w_ram_re) r_q <= r_mem[w_ram_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pend_v    <= 1'b0;
      r_pend_type <= P_RD;
      r_mon_a     <= '0;
      r_mon_d     <= '0;
      r_ready     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_queue) begin
        r_pend_v    <= 1'b1;
        r_pend_type <= w_win_b ? P_WR : (w_win_n ? P_RDINC : P_RD);
      end else if (r_state == IDLE && r_pend_v) begin
        r_pend_v <= 1'b0;
      end

      if (w_accept && w_win_a)
        r_mon_a <= jdo[17+ADDR_W:18];
      else if (w_jwr_done || (w_jcap && r_pend_type == P_RDINC))
        r_mon_a <= ADDR_W'(r_mon_a + 1'b1);

      if (w_accept && w_win_b) r_mon_d <= jdo[34:3];
      else if (w_jcap)         r_mon_d <= r_q;

      if (w_queue)                                         r_ready <= 1'b0;
      else if ((w_accept && w_win_a) || w_jwr_done || w_jcap) r_ready <= 1'b1;

      if (w_drop)                                r_error <= 1'b1;
      else if (w_accept && w_win_a && jdo[34])   r_error <= 1'b0;
    end
  end

  assign readdata      = (r_state == CPU_RD) ? r_q : '0;
  assign waitrequest   = ((read | write) & ((r_state == J_CAP) |
                          ((r_state == IDLE) & (r_pend_v | w_queue))))
                       | (read & (r_state == IDLE));
  assign MonDReg       = r_mon_d;
  assign MonAReg       = r_mon_a;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;

endmodule

// File: tb/tb_cpu_jtag_ocimem.sv
// Directed self-checking bench for cpu_jtag_ocimem (ADDR_W=8).
module tb_cpu_jtag_ocimem;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        monitor_ready, monitor_error;

  int nerr = 0;
  int nchk = 0;

  cpu_jtag_ocimem #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .waitrequest(waitrequest),
    .MonDReg(MonDReg), .MonAReg(MonAReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic strobe_a(input logic [7:0] a, input logic rd, input logic clr);
    jdo = '0; jdo[25:18] = a; jdo[35] = rd; jdo[34] = clr;
    take_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0; jdo = '0;
  endtask

  task automatic strobe_b(input logic [31:0] d);
    jdo = '0; jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    step();
    take_action_ocimem_b = 1'b0; jdo = '0;
  endtask

  task automatic strobe_n();
    take_no_action_ocimem_a = 1'b1;
    step();
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                           output logic w0);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    #1 w0 = waitrequest;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  // Holds read until waitrequest drops; strobes are released after the first edge.
  task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int waits);
    logic done;
    address = a; read = 1'b1; waits = 0; done = 1'b0; d = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (!waitrequest) begin
        d = readdata; done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
      take_action_ocimem_b = 1'b0; take_action_ocimem_a = 1'b0;
      take_no_action_ocimem_a = 1'b0; jdo = '0;
    end
    read = 1'b0;
    chk("cpu_read_completes", {31'd0, done}, 32'd1);
  endtask

  logic [31:0] rd;
  int          w;
  logic        w0;

  initial begin
    reset_n = 1'b0; jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0;
    step(); step();
    chk("rst_MonDReg", MonDReg, 32'h0);
    chk("rst_MonAReg", {24'd0, MonAReg}, 32'h0);
    chk("rst_ready", {31'd0, monitor_ready}, 32'h0);
    chk("rst_error", {31'd0, monitor_error}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_waitrequest", {31'd0, waitrequest}, 32'h0);
    reset_n = 1'b1;
    step();

    // JTAG write then read back
    strobe_a(8'h10, 1'b0, 1'b0);
    chk("addr_load_MonAReg", {24'd0, MonAReg}, 32'h10);
    chk("addr_load_ready", {31'd0, monitor_ready}, 32'h1);
    step(); step();
    strobe_b(32'hDEADBEEF);
    chk("wr_T1_ready", {31'd0, monitor_ready}, 32'h0);
    step();
    chk("wr_T2_ready", {31'd0, monitor_ready}, 32'h1);
    chk("wr_T2_MonAReg", {24'd0, MonAReg}, 32'h11);
    step();
    strobe_b(32'h12345678);
    step(); step();
    chk("wr2_MonAReg", {24'd0, MonAReg}, 32'h12);
    strobe_a(8'h10, 1'b1, 1'b0);
    step();
    chk("rd_T2_ready", {31'd0, monitor_ready}, 32'h0);
    step();
    chk("rd_T3_MonDReg", MonDReg, 32'hDEADBEEF);
    chk("rd_T3_ready", {31'd0, monitor_ready}, 32'h1);
    chk("rd_T3_MonAReg", {24'd0, MonAReg}, 32'h10);
    cpu_read(8'h11, rd, w);
    chk("cpu_rd_0x11", rd, 32'h12345678);
    chk("cpu_rd_waits", w, 32'd1);

    // Read-next with wrap
    cpu_write(8'hFF, 32'h1, 4'hF, w0);
    chk("cpu_wr_wait0", {31'd0, w0}, 32'h0);
    cpu_write(8'h00, 32'h2, 4'hF, w0);
    strobe_a(8'hFF, 1'b0, 1'b0);
    step(); step();
    strobe_n();
    step(); step();
    chk("rdinc1_MonDReg", MonDReg, 32'h1);
    chk("rdinc1_MonAReg", {24'd0, MonAReg}, 32'h00);
    step();
    strobe_n();
    step(); step();
    chk("rdinc2_MonDReg", MonDReg, 32'h2);
    chk("rdinc2_MonAReg", {24'd0, MonAReg}, 32'h01);
    step();

    // Arbitration: CPU read held with a JTAG write in the same cycle
    cpu_write(8'h20, 32'h11111111, 4'hF, w0);
    strobe_a(8'h20, 1'b0, 1'b0);
    step(); step();
    jdo = '0; jdo[34:3] = 32'h22222222; take_action_ocimem_b = 1'b1;
    cpu_read(8'h20, rd, w);
    chk("arb_data", rd, 32'h22222222);
    chk("arb_waits_ge2", {31'd0, (w >= 2)}, 32'h1);
    chk("arb_MonAReg", {24'd0, MonAReg}, 32'h21);
    step();

    // Overflow: second strobe while pend_v=1 is dropped
    strobe_b(32'h33333333);
    strobe_b(32'h44444444);
    chk("ovf_error", {31'd0, monitor_error}, 32'h1);
    chk("ovf_MonDReg", MonDReg, 32'h33333333);
    chk("ovf_MonAReg", {24'd0, MonAReg}, 32'h22);
    step(); step();
    strobe_a(8'h21, 1'b1, 1'b1);
    chk("clr_error", {31'd0, monitor_error}, 32'h0);
    step(); step();
    chk("ovf_readback", MonDReg, 32'h33333333);
    step();

    // CPU byte enables
    cpu_write(8'h05, 32'h0, 4'hF, w0);
    cpu_write(8'h05, 32'hAABBCCDD, 4'h3, w0);
    chk("be_wr_wait0", {31'd0, w0}, 32'h0);
    cpu_read(8'h05, rd, w);
    chk("be_data", rd, 32'h0000CCDD);
    chk("be_waits", w, 32'd1);

    // Async reset while in J_CAP
    strobe_a(8'h10, 1'b1, 1'b0);
    step();
    reset_n = 1'b0;
    #1;
    chk("arst_MonDReg", MonDReg, 32'h0);
    chk("arst_MonAReg", {24'd0, MonAReg}, 32'h0);
    chk("arst_ready", {31'd0, monitor_ready}, 32'h0);
    chk("arst_error", {31'd0, monitor_error}, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, monitor_ready}, 32'h0);
    cpu_read(8'h10, rd, w);
    chk("arst_ram_kept", rd, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
